// File: rtl/ksa_seq_ctrl_pkg.sv
// Shared definitions for the sequential Kogge-Stone adder controller:
// FSM state encodings and default operand/slice widths.
package ksa_seq_ctrl_pkg;

   localparam int DEF_WIDTH = 64;
   localparam int DEF_SLICE = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : ksa_seq_ctrl_pkg

// File: rtl/ksa_seq_ctrl_slice.sv
// Purely combinational W-bit Kogge-Stone adder with carry-in and carry-out.
// The carry-in is folded into the bit-0 generate term, so the prefix tree
// directly yields the carry into every bit position.
module ksa_seq_ctrl_slice #(
   parameter int W = 16
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_cin,
   output logic [W-1:0] o_sum,
   output logic         o_cout
);

   localparam int L = (W > 1) ? $clog2(W) : 0;

   logic [W-1:0] w_p0;
   logic [W-1:0] w_g0;
   logic [W-1:0] w_gf;
   logic [W:0]   w_c;

   // Pre-processing: bitwise propagate/generate, carry-in merged into bit 0.
   assign w_p0 = i_a ^ i_b;
   assign w_g0 = (i_a & i_b) | W'(w_p0[0] & i_cin);

   // Prefix stages: each level doubles the span of every group (g,p) pair.
   for (genvar lv = 0; lv < L; lv++) begin : g_lvl
      localparam int D = 1 << lv;
      logic [W-1:0] w_gi;
      logic [W-1:0] w_pi;
      logic [W-1:0] w_g;

      if (lv == 0) begin : g_src0
         assign w_gi = w_g0;
         assign w_pi = w_p0;
      end else begin : g_srcn
         assign w_gi = g_lvl[lv-1].w_g;
         assign w_pi = g_lvl[lv-1].g_pp.w_p;
      end

      assign w_g = w_gi | (w_pi & (w_gi << D));

      // The last level only needs group generate, so propagate stops one short.
      if (lv < L - 1) begin : g_pp
         logic [W-1:0] w_p;
         assign w_p = w_pi & (w_pi << D);
      end
   end

   if (L == 0) begin : g_gf_flat
      assign w_gf = w_g0;
   end else begin : g_gf_tree
      assign w_gf = g_lvl[L-1].w_g;
   end

   // Post-processing: carry into bit i is the group generate of bits [i-1:0].
   assign w_c    = {w_gf, i_cin};
   assign o_sum  = w_p0 ^ w_c[W-1:0];
   assign o_cout = w_c[W];

endmodule : ksa_seq_ctrl_slice

// File: rtl/ksa_seq_ctrl.sv
// Sequential WIDTH-bit adder: one SLICE-bit Kogge-Stone slice is reused over
// NS = WIDTH/SLICE beats, least significant slice first, with a valid/ready
// handshake on both the operand and the result side.
module ksa_seq_ctrl
   import ksa_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_in_valid,
   output logic             o_in_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_out_valid,
   input  logic             i_out_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf
);

   localparam int NS = WIDTH / SLICE;
   localparam int CW = (NS > 1) ? $clog2(NS) : 1;

   state_e           r_state;
   state_e           w_next;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;

   logic             w_accept;
   logic             w_last;
   logic [SLICE-1:0] w_slice_a;
   logic [SLICE-1:0] w_slice_b;
   logic [SLICE-1:0] w_slice_sum;
   logic             w_slice_cout;

   assign w_accept  = i_in_valid & o_in_ready;
   assign w_last    = (r_cnt == CW'(NS - 1));
   assign w_slice_a = r_a[int'(r_cnt) * SLICE +: SLICE];
   assign w_slice_b = r_b[int'(r_cnt) * SLICE +: SLICE];

   ksa_seq_ctrl_slice #(
      .W (SLICE)
   ) u_slice (
      .i_a    (w_slice_a),
      .i_b    (w_slice_b),
      .i_cin  (r_carry),
      .o_sum  (w_slice_sum),
      .o_cout (w_slice_cout)
   );

   // Next-state and handshake decode.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
      w_next      = r_state;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_in_ready = 1'b1;
            if (i_in_valid) w_next = ST_RUN;
         end
         ST_RUN: begin
            if (w_last) w_next = ST_DONE;
         end
         ST_DONE: begin
            o_out_valid = 1'b1;
            o_in_ready  = i_out_ready;
            if (i_out_ready) w_next = i_in_valid ? ST_RUN : ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // State register; reset aborts any operation in flight.
   always_ff @(posedge i_clk) begin
      // NOTE: clocked state uses non-blocking assignments so all registers update together from pre-edge values.
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   // Operand capture on accept; held constant through the RUN beats.
   always_ff @(posedge i_clk) begin
      // NOTE: operand registers are pure data, qualified by the FSM, so they carry no reset.
      if (w_accept) begin
         r_a <= i_a;
         r_b <= i_b;
      end
   end

   // Beat counter, carry chain and result registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_carry <= i_cin;
      end else if (r_state == ST_RUN) begin
         r_sum[int'(r_cnt) * SLICE +: SLICE] <= w_slice_sum;
         r_carry <= w_slice_cout;
         if (w_last) begin
            r_cout <= w_slice_cout;
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &
                      (w_slice_sum[SLICE-1] != r_a[WIDTH-1]);
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_sum  = r_sum;
   assign o_cout = r_cout;
   assign o_ovf  = r_ovf;

endmodule : ksa_seq_ctrl

// File: doc/ksa_seq_ctrl.md
KSA_SEQ_CTRL -- requirements
Module: ksa_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 64, total operand width; SHALL be an integer multiple of SLICE.
REQ-002 Parameter SLICE, default 16, width of the shared Kogge-Stone adder slice.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  requester presents operands.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 cin  input  1  carry-in.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 sum  output  WIDTH  result.
REQ-012 cout  output  1  carry-out of bit WIDTH-1.
REQ-013 ovf  output  1  signed overflow (two's complement).

Function
REQ-014 Block SHALL compute {cout,sum} = a + b + cin using one SLICE-bit Kogge-Stone adder instance, time-multiplexed over NS = WIDTH/SLICE beats.
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 Accept = in_valid & in_ready; on accept, a, b, cin SHALL be latched into operand registers; beat counter cleared to 0; state -> RUN.
REQ-017 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, 0 otherwise (including all of RUN).
REQ-018 In RUN beat k (k = 0..NS-1) the slice SHALL add operand bits [k*SLICE +: SLICE] with carry register (cin for k=0); slice sum written to sum[k*SLICE +: SLICE]; slice carry-out written to carry register.
REQ-019 After beat NS-1: cout = final carry, ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]); state -> DONE.
REQ-020 Latency: accept at edge T, out_valid SHALL rise at edge T+NS (NS=4: 4 cycles), no bubble.
REQ-021 In DONE out_valid SHALL be 1; sum, cout, ovf SHALL hold stable until handshake out_valid & out_ready.
REQ-022 DONE with out_ready=1 and in_valid=0 SHALL go to IDLE; out_valid low next cycle.
REQ-023 DONE with out_ready=1 and in_valid=1 (simultaneous release/accept) SHALL accept new operands and go directly to RUN; throughput one op per NS+1 cycles.
REQ-024 out_valid SHALL be 0 in IDLE and RUN; sum/cout/ovf SHALL be don't-care outside DONE but SHALL not change in DONE.
REQ-025 in_valid while in_ready=0 SHALL be ignored; operands not sampled; requester holds them.
REQ-026 Beat counter width clog2(NS), max(1); no wrap beyond NS-1.

Reset
REQ-027 When rst_n=0 at a rising edge: state -> IDLE, counter 0, carry 0, sum 0, cout 0, ovf 0, out_valid 0; in_ready 1 from the next cycle.
REQ-028 Reset in RUN or DONE SHALL abort the operation; partial result discarded, no out_valid emitted.
REQ-029 rst_n SHALL have priority over all handshakes in the same cycle.

Structure
REQ-030 Shared include ksa_defs.vh SHALL hold state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default WIDTH/SLICE.
REQ-031 One sub-module ksa_slice (SLICE-bit combinational Kogge-Stone adder: p/g pre-processing, log2(SLICE) prefix stages, sum post-processing, cin/cout) SHALL be instantiated exactly once.
REQ-032 Controller SHALL hold all registers; ksa_slice SHALL contain no state.

Verification
REQ-033 a=0x0000_0000_0000_FFFF, b=1, cin=0 -> sum=0x0000_0000_0001_0000, cout=0, ovf=0, out_valid at accept+4.
REQ-034 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, ovf=0 (full carry ripple across all 4 beats).
REQ-035 a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-036 out_ready held 0 for 5 cycles in DONE -> sum/cout/ovf stable, in_ready=0; then out_ready=1 with in_valid=1 -> new op accepted same cycle, next result 4 cycles later.
REQ-037 rst_n=0 at RUN beat 2 -> out_valid never asserts for that op; next op (a=5, b=7) -> sum=12.
REQ-038 Random back-to-back ops with random out_ready stalls, 10k ops -> all match reference model a+b+cin, no lost/duplicated results.
